// File: rtl/boot_loader.sv
// boot_loader: owns the UART RX/TX FIFOs after reset and loads a length-prefixed,
// little-endian word image into instruction memory while holding the core halted.
// Then it sends an acknowledge byte, releases the core and becomes a transparent
// UART pass-through.
// Optional feature macro: BOOT_CHECKSUM_EN adds a 4-byte sum trailer and a retry path.
module boot_loader #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [7:0]  ACK_OK  = 8'hAA,
  parameter logic [7:0]  ACK_BAD = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_empty,
  input  logic [7:0]        uart_in,
  output logic              uart_rdreq,
  output logic              uart_wrreq,
  output logic [7:0]        uart_out,
  input  logic              cpu_uart_rdreq,
  input  logic              cpu_uart_wrreq,
  input  logic [7:0]        cpu_uart_out,
  output logic              cpu_uart_empty,
  output logic [7:0]        cpu_uart_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {StLen, StData, StCsum, StAck, StRun} state_t;
`else
  typedef enum logic [2:0] {StLen, StData, StAck, StRun} state_t;
`endif

  state_t             r_state;
  logic               r_rdreq;    // pop issued this cycle
  logic               r_cap;      // popped byte is on uart_in this cycle
  logic [1:0]         r_bcnt;     // byte position within the current 4-byte group
  logic [31:0]        r_word;
  logic [31:0]        r_len;
  logic [31:0]        r_idx;
  logic               r_ackd;     // ACK pulse already issued, leave ACK next
  logic               r_wrreq;
  logic [7:0]         r_out;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               r_cpu_run;
  logic               r_err;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]        r_sum;
  logic               r_bad;
`endif

  logic        w_fetch;
  logic        w_last;
  logic        w_run;
  logic [31:0] w_full;

  assign w_run   = (r_state == StRun);
`ifdef BOOT_CHECKSUM_EN
  assign w_fetch = (r_state == StLen) || (r_state == StData) || (r_state == StCsum);
`else
  assign w_fetch = (r_state == StLen) || (r_state == StData);
`endif
  // Word as it will look once the byte on uart_in is shifted in.
  assign w_full  = {uart_in, r_word[31:8]};
  // Capturing the 4th byte of a group: the state may change, so no new pop this edge.
  assign w_last  = r_cap && (r_bcnt == 2'd3);

  // Byte fetch, word assembly and the load sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StLen;
      r_rdreq   <= 1'b0;
      r_cap     <= 1'b0;
      r_bcnt    <= 2'd0;
      r_word    <= 32'd0;
      r_len     <= 32'd0;
      r_idx     <= 32'd0;
      r_ackd    <= 1'b0;
      r_wrreq   <= 1'b0;
      r_out     <= 8'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_cpu_run <= 1'b0;
      r_err     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum     <= 32'd0;
      r_bad     <= 1'b0;
`endif
    end else begin
      r_we    <= 1'b0;
      r_wrreq <= 1'b0;
      r_cap   <= r_rdreq;
      r_rdreq <= w_fetch && !uart_empty && !r_rdreq && !w_last;
      if (r_cap) begin
        r_word <= w_full;
        r_bcnt <= r_bcnt + 2'd1;
      end
      unique case (r_state)
        StLen: begin
          if (w_last) begin
            r_len <= w_full;
            r_idx <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            r_sum <= 32'd0;
            r_state <= (w_full == 32'd0) ? StCsum : StData;
`else
            if (w_full == 32'd0) begin
              r_wrreq <= 1'b1;
              r_out   <= ACK_OK;
              r_ackd  <= 1'b1;
              r_state <= StAck;
            end else begin
              r_state <= StData;
            end
`endif
          end
        end
        StData: begin
          if (w_last) begin
            if (r_idx[31:ADDR_W] == '0) begin
              r_we    <= 1'b1;
              r_addr  <= r_idx[ADDR_W-1:0];
              r_wdata <= w_full;
            end else begin
              r_err <= 1'b1;
            end
            r_idx <= r_idx + 32'd1;
`ifdef BOOT_CHECKSUM_EN
            r_sum <= r_sum + w_full;
            if (r_idx == r_len - 32'd1) r_state <= StCsum;
`else
            if (r_idx == r_len - 32'd1) begin
              r_ackd  <= 1'b0;
              r_state <= StAck;
            end
`endif
          end
        end
`ifdef BOOT_CHECKSUM_EN
        StCsum: begin
          if (w_last) begin
            r_wrreq <= 1'b1;
            r_ackd  <= 1'b1;
            r_state <= StAck;
            if (w_full == r_sum) begin
              r_out <= ACK_OK;
            end else begin
              r_out <= ACK_BAD;
              r_err <= 1'b1;
              r_bad <= 1'b1;
            end
          end
        end
`endif
        StAck: begin
          if (!r_ackd) begin
            r_wrreq <= 1'b1;
            r_out   <= ACK_OK;
            r_ackd  <= 1'b1;
          end else begin
            r_ackd <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            if (r_bad) begin
              r_bad   <= 1'b0;
              r_state <= StLen;
            end else begin
              r_cpu_run <= 1'b1;
              r_state   <= StRun;
            end
`else
            r_cpu_run <= 1'b1;
            r_state   <= StRun;
`endif
          end
        end
        StRun: ;
        default: r_state <= StLen;
      endcase
    end
  end

  // Registered outputs while loading; core owns the FIFOs once running.
  always_comb begin
    uart_rdreq     = w_run ? cpu_uart_rdreq : r_rdreq;
    uart_wrreq     = w_run ? cpu_uart_wrreq : r_wrreq;
    uart_out       = w_run ? cpu_uart_out   : r_out;
    cpu_uart_empty = w_run ? uart_empty     : 1'b1;
    cpu_uart_in    = w_run ? uart_in        : 8'd0;
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_run    = r_cpu_run;
  assign load_err   = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: a FIFO model feeds the byte stream, the image
// model pushes expected memory writes and ACK bytes, and a monitor checks them.
// Honours BOOT_CHECKSUM_EN to append the sum trailer and exercise the retry path.
module tb_boot_loader;
  localparam int unsigned ADDR_W  = 2;
  localparam int          CAP     = 1 << ADDR_W;
  localparam logic [7:0]  ACK_OK  = 8'hAA;
  localparam logic [7:0]  ACK_BAD = 8'h55;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              uart_empty = 1'b1;
  logic [7:0]        uart_in = 8'd0;
  logic              uart_rdreq, uart_wrreq;
  logic [7:0]        uart_out;
  logic              cpu_uart_rdreq = 1'b0;
  logic              cpu_uart_wrreq = 1'b0;
  logic [7:0]        cpu_uart_out = 8'd0;
  logic              cpu_uart_empty;
  logic [7:0]        cpu_uart_in;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run, load_err;

  boot_loader #(.ADDR_W(ADDR_W), .ACK_OK(ACK_OK), .ACK_BAD(ACK_BAD)) dut (
    .clk(clk), .rst(rst), .uart_empty(uart_empty), .uart_in(uart_in),
    .uart_rdreq(uart_rdreq), .uart_wrreq(uart_wrreq), .uart_out(uart_out),
    .cpu_uart_rdreq(cpu_uart_rdreq), .cpu_uart_wrreq(cpu_uart_wrreq),
    .cpu_uart_out(cpu_uart_out), .cpu_uart_empty(cpu_uart_empty), .cpu_uart_in(cpu_uart_in),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ack;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_t;   // ACK must follow the last write by one cycle
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] img_w[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, acks = 0, pops = 0, stall_at = -1, stall_left = 0, last_we_cyc = -10;
  bit err_model = 1'b0, run_pend = 1'b0, run_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model: pops on uart_rdreq, byte visible the following cycle; optional stall.
  always @(negedge clk) begin
    if (!rst && !cpu_run) chk("rdreq_while_empty", uart_rdreq && uart_empty, 0);
    if (uart_rdreq && rx_q.size() > 0) begin
      uart_in = rx_q.pop_front();
      pops++;
      if (pops == stall_at) stall_left = 20;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    uart_empty = (rx_q.size() == 0) || (stall_left > 0);
  end

  // Monitor: pop and compare on every imem write and every loader ACK pulse.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      if (run_pend) begin
        chk("run_after_ack", cpu_run, run_exp);
        run_pend = 1'b0;
      end
      if (!cpu_run) chk("cpu_view_idle", {cpu_uart_empty, cpu_uart_in}, {1'b1, 8'h00});
      if (imem_we) begin
        ok = (exp_q.size() > 0) && !exp_q[0].is_ack;
        chk("we_expected", ok, 1);
        if (ok) begin
          e = exp_q.pop_front();
          chk("we_addr", imem_addr, e.addr);
          chk("we_data", imem_wdata, e.data);
        end
        last_we_cyc = cyc;
      end
      if (uart_wrreq && !cpu_run) begin
        ok = (exp_q.size() > 0) && exp_q[0].is_ack;
        chk("ack_expected", ok, 1);
        if (ok) begin
          e = exp_q.pop_front();
          chk("ack_byte", uart_out, e.data[7:0]);
          if (e.chk_t) chk("ack_latency", cyc, last_we_cyc + 1);
          run_exp = (e.data[7:0] == ACK_OK);
        end
        run_pend = 1'b1;
        acks++;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) rx_q.push_back(w[8*b +: 8]);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    rx_q.delete();
    exp_q.delete();
    err_model = 1'b0;
    stall_at = -1;
    run_pend = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_rdreq", uart_rdreq, 0);
    chk("rst_uart_wrreq", uart_wrreq, 0);
    chk("rst_uart_out", uart_out, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_cpu_uart_empty", cpu_uart_empty, 1);
    chk("rst_cpu_uart_in", cpu_uart_in, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference: N words, word i lands at address i if it fits, mod-2^32 sum trailer.
  task automatic load(input int n, input logic [31:0] corrupt);
    logic [31:0] sum;
    exp_t        e;
    int          tgt, budget, k;
    bit          want_run;
    sum = 32'd0;
    push_word(n);
    for (int i = 0; i < n; i++) begin
      push_word(img_w[i]);
      sum += img_w[i];
      if (i < CAP) begin
        e.is_ack = 1'b0; e.addr = i; e.data = img_w[i]; e.chk_t = 1'b0;
        exp_q.push_back(e);
      end else begin
        err_model = 1'b1;
      end
    end
    e.is_ack = 1'b1;
    e.addr = 32'd0;
`ifdef BOOT_CHECKSUM_EN
    push_word(sum + corrupt);
    if (corrupt != 0) err_model = 1'b1;
    e.data = {24'd0, (corrupt != 0) ? ACK_BAD : ACK_OK};
    e.chk_t = 1'b0;
    want_run = (corrupt == 0);
`else
    e.data = {24'd0, ACK_OK};
    e.chk_t = (n > 0) && (n <= CAP);
    want_run = 1'b1;
`endif
    exp_q.push_back(e);
    tgt = acks + 1;
    budget = 80 + 3 * 4 * (n + 2);
    k = 0;
    while (acks < tgt && k < budget) begin
      tick();
      k++;
    end
    chk("ack_seen", acks >= tgt, 1);
    tick();
    tick();
    chk("load_err", load_err, err_model);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("cpu_run", cpu_run, want_run);
  endtask

  task automatic rand_img(input int n);
    img_w.delete();
    for (int i = 0; i < n; i++) img_w.push_back($urandom());
  endtask

  initial begin
    exp_t e;
    int   n, k;
    do_reset();

    // Directed image from the reference example.
    img_w.delete();
    img_w.push_back(32'h0010_0513);
    img_w.push_back(32'h0000_006F);
    load(2, 0);

    // Empty image, then pass-through in both directions.
    do_reset();
    img_w.delete();
    load(0, 0);
    rx_q.push_back(8'h5A);
    tick();
    tick();
    chk("pt_empty_low", cpu_uart_empty, 0);
    cpu_uart_rdreq = 1'b1;
    #1 chk("pt_rdreq", uart_rdreq, 1);
    tick();
    cpu_uart_rdreq = 1'b0;
    tick();
    chk("pt_data", cpu_uart_in, 8'h5A);
    chk("pt_empty_high", cpu_uart_empty, 1);
    cpu_uart_wrreq = 1'b1;
    cpu_uart_out = 8'h41;
    #1;
    chk("pt_wrreq", uart_wrreq, 1);
    chk("pt_out", uart_out, 8'h41);
    tick();
    cpu_uart_wrreq = 1'b0;
    cpu_uart_out = 8'h00;

    // Overflow: fifth word exceeds capacity.
    do_reset();
    rand_img(5);
    load(5, 0);

    // Reset after 6 data bytes of a 2-word image, then a fresh load.
    do_reset();
    rand_img(2);
    push_word(2);
    push_word(img_w[0]);
    rx_q.push_back(img_w[1][7:0]);
    rx_q.push_back(img_w[1][15:8]);
    e.is_ack = 1'b0; e.addr = 0; e.data = img_w[0]; e.chk_t = 1'b0;
    exp_q.push_back(e);
    k = 0;
    while (rx_q.size() > 0 && k < 100) begin
      tick();
      k++;
    end
    repeat (6) tick();
    chk("partial_word0_written", exp_q.size(), 0);
    chk("partial_no_run", cpu_run, 0);
    do_reset();
    rand_img(2);
    load(2, 0);

    // RX stall of 20 cycles in the middle of word 0.
    do_reset();
    rand_img(3);
    stall_at = pops + 6;
    load(3, 0);

    // Randomised images with random stall points.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(0, 6);
      rand_img(n);
      if ($urandom_range(0, 1) == 1) stall_at = pops + $urandom_range(1, 4 * (n + 1));
      load(n, 0);
    end

`ifdef BOOT_CHECKSUM_EN
    // Bad trailer returns to length phase; resend with a good trailer.
    do_reset();
    img_w.delete();
    img_w.push_back(32'h0000_0001);
    load(1, 1);
    load(1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case something wedges the stimulus flow.
  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
